add_pipe_nbit: RTL and testbench

Parametrised pipelined add/subtract unit, the successor to the single-bit sum/carry adder. Splits a WIDTH-bit operation into STAGES chunk-wide carry-propagate stages, one chunk per cycle. Accepts one operation per cycle with valid/ready handshake on both sides. Used wherever the datapath needs wide adds without a long combinational carry chain.

---
 rtl/add_pipe_nbit_if.sv | 26 ++
 rtl/add_pipe_nbit.sv | 114 +++++++++++
 tb/tb_add_pipe_nbit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/add_pipe_nbit_if.sv
// Handshake/operand bundle for add_pipe_nbit: upstream operand channel and downstream result channel.
interface add_pipe_nbit_if #(
  parameter int WIDTH = 16
);
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic             sub_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             ovf_out;

  modport slave (
    input  valid_in, a_in, b_in, carry_in, sub_in, ready_in,
    output ready_out, valid_out, sum_out, carry_out, ovf_out
  );

  modport master (
    output valid_in, a_in, b_in, carry_in, sub_in, ready_in,
    input  ready_out, valid_out, sum_out, carry_out, ovf_out
  );
endinterface

// File: rtl/add_pipe_nbit.sv
// Pipelined WIDTH-bit add/subtract: one CW-bit carry-propagate chunk per stage, whole pipe
// freezes when the registered result is held by downstream.
module add_pipe_nbit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic           clk_in,
  input logic           rst_in,
  add_pipe_nbit_if.slave io
);
  localparam int CW = WIDTH / STAGES;

  logic [STAGES:0] vld_pipe;
  logic            en;

  assign vld_pipe[0]  = io.valid_in;
  assign en           = !(vld_pipe[STAGES] && !io.ready_in);
  assign io.ready_out = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * CW;     // result bits already resolved upstream
    localparam int REM = WIDTH - LO; // operand bits still pending, incl. this chunk

    logic [REM-1:0]     a_rem;
    logic [REM-1:0]     b_rem;
    logic               c_prev;
    logic [CW:0]        add_res;
    logic [LO+CW-1:0]   sum_nxt;
    logic [LO+CW-1:0]   sum_d, sum_q;
    logic               carry_d, carry_q;
    logic               vld_d, vld_q;

    if (k == 0) begin : g_src
      assign a_rem   = io.a_in;
      assign b_rem   = io.sub_in ? ~io.b_in : io.b_in;
      assign c_prev  = io.sub_in | io.carry_in;
      assign sum_nxt = add_res[CW-1:0];
    end else begin : g_src
      assign a_rem   = g_stg[k-1].g_fwd.a_fwd_q;
      assign b_rem   = g_stg[k-1].g_fwd.b_fwd_q;
      assign c_prev  = g_stg[k-1].carry_q;
      assign sum_nxt = {add_res[CW-1:0], g_stg[k-1].sum_q};
    end

    assign add_res      = {1'b0, a_rem[CW-1:0]} + {1'b0, b_rem[CW-1:0]} + {{CW{1'b0}}, c_prev};
    assign vld_pipe[k+1] = vld_q;

    always_comb begin
      vld_d   = vld_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      if (en) begin
        vld_d   = vld_pipe[k];
        carry_d = add_res[CW];
        sum_d   = sum_nxt;
      end
    end

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        vld_q   <= vld_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Skew registers carry the not-yet-added upper operand chunks alongside.
      logic [REM-CW-1:0] a_fwd_d, a_fwd_q;
      logic [REM-CW-1:0] b_fwd_d, b_fwd_q;

      always_comb begin
        a_fwd_d = a_fwd_q;
        b_fwd_d = b_fwd_q;
        if (en) begin
          a_fwd_d = a_rem[REM-1:CW];
          b_fwd_d = b_rem[REM-1:CW];
        end
      end

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          a_fwd_q <= '0;
          b_fwd_q <= '0;
        end else begin
          a_fwd_q <= a_fwd_d;
          b_fwd_q <= b_fwd_d;
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = ovf_q;
        if (en)
          ovf_d = (a_rem[CW-1] == b_rem[CW-1]) && (add_res[CW-1] != a_rem[CW-1]);
      end

      always_ff @(posedge clk_in) begin
        if (rst_in) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
      end
    end
  end

  assign io.valid_out = vld_pipe[STAGES];
  assign io.sum_out   = g_stg[STAGES-1].sum_q;
  assign io.carry_out = g_stg[STAGES-1].carry_q;
  assign io.ovf_out   = g_stg[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_add_pipe_nbit.sv
// Randomised + directed bench for add_pipe_nbit against an integer-arithmetic reference.
module tb_add_pipe_nbit;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    int               acc_cyc;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  add_pipe_nbit_if #(.WIDTH(WIDTH)) io ();

  add_pipe_nbit #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .io    (io.slave)
  );

  always #5 clk_in = ~clk_in;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t pend;
  int   cyc = 0;
  int   last_stall = -1;
  bit   head_seen = 0;
  bit   post_rst = 0;
  int   rdy_low = 0;
  int   n_emit = 0;
  bit   rnd_rdy = 0;
  bit   stall_arm = 0;
  int   stall_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci, input logic sb);
    exp_t m;
    int   r;
    if (sb) begin
      r       = int'($signed(a)) - int'($signed(b));
      m.sum   = 16'(a - b);
      m.carry = (a >= b);
    end else begin
      r       = int'($signed(a)) + int'($signed(b)) + int'(ci);
      m.sum   = 16'(a + b + {15'd0, ci});
      m.carry = (int'(a) + int'(b) + int'(ci)) > 65535;
    end
    m.ovf     = (r > 32767) || (r < -32768);
    m.acc_cyc = 0;
    return m;
  endfunction

  always @(negedge clk_in) begin
    exp_t e;
    cyc++;
    if (rst_in) begin
      exp_q.delete();
      head_seen = 0;
      post_rst  = 1;
    end else begin
      if (post_rst) begin
        chk("rst_vld",   32'(io.valid_out), 32'd0);
        chk("rst_sum",   32'(io.sum_out),   32'd0);
        chk("rst_carry", 32'(io.carry_out), 32'd0);
        chk("rst_ovf",   32'(io.ovf_out),   32'd0);
        chk("rst_rdy",   32'(io.ready_out), 32'd1);
        post_rst = 0;
      end
      chk("rdy_rule", 32'(io.ready_out), 32'(!(io.valid_out && !io.ready_in)));
      if (!io.ready_out) rdy_low++;
      if (io.valid_out) begin
        if (exp_q.size() == 0) chk("stale", 32'd1, 32'd0);
        else begin
          e = exp_q[0];
          if (!head_seen && last_stall < e.acc_cyc)
            chk("latency", 32'(cyc - e.acc_cyc), 32'(STAGES));
          head_seen = 1;
          chk("sum",   32'(io.sum_out),   32'(e.sum));
          chk("carry", 32'(io.carry_out), 32'(e.carry));
          chk("ovf",   32'(io.ovf_out),   32'(e.ovf));
          if (io.ready_in) begin
            void'(exp_q.pop_front());
            head_seen = 0;
            n_emit++;
          end
        end
        if (!io.ready_in) last_stall = cyc;
      end
      if (io.valid_in && io.ready_out) begin
        e         = pend;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (stall_arm && io.valid_out) begin
      stall_left = 3;
      stall_arm  = 0;
    end
    if (stall_left > 0) begin
      io.ready_in = 1'b0;
      stall_left--;
    end else
      io.ready_in = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic send_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic ci, input logic sb, input exp_t e);
    int acc;
    int n = 0;
    pend        = e;
    io.a_in     = a;
    io.b_in     = b;
    io.carry_in = ci;
    io.sub_in   = sb;
    io.valid_in = 1'b1;
    do begin
      @(negedge clk_in);
      acc = int'(io.ready_out);
      tick();
      n++;
    end while (acc == 0 && n < 100);
    if (acc == 0) chk("send_timeout", 32'd1, 32'd0);
    io.valid_in = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic ci, input logic sb);
    send_exp(a, b, ci, sb, model(a, b, ci, sb));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    logic [WIDTH-1:0] c [4];
    c[0] = 16'h0000; c[1] = 16'hFFFF; c[2] = 16'h7FFF; c[3] = 16'h8000;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  // Directed vectors with hand-derived expectations (sum, carry, ovf).
  typedef struct {
    logic [WIDTH-1:0] a, b;
    logic ci, sb;
    logic [WIDTH-1:0] sum;
    logic carry, ovf;
  } vec_t;

  initial begin
    vec_t  vt [9];
    exp_t  e;
    int    r0, e0;
    io.valid_in = 1'b0;
    io.a_in     = '0;
    io.b_in     = '0;
    io.carry_in = 1'b0;
    io.sub_in   = 1'b0;
    io.ready_in = 1'b1;
    pend        = model(16'd0, 16'd0, 1'b0, 1'b0);

    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
    vt[6] = '{16'h1234, 16'h0FFF, 1'b1, 1'b1, 16'h0235, 1'b1, 1'b0};
    vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[8] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

    tick(); tick();
    rst_in = 1'b0;
    tick();

    // Directed corner vectors, back to back.
    for (int i = 0; i < 9; i++) begin
      e = '{vt[i].sum, vt[i].carry, vt[i].ovf, 0};
      send_exp(vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, e);
    end
    drain("drain_dir");

    // 8-op stream with a 3-cycle downstream stall once results appear.
    r0 = rdy_low;
    e0 = n_emit;
    stall_arm = 1;
    for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
    drain("drain_stall");
    chk("stall_rdy_low", 32'(rdy_low - r0), 32'd3);
    chk("stall_emits",   32'(n_emit - e0),  32'd8);

    // Reset with 3 ops in flight; none may surface afterwards.
    for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    drain("drain_rst");

    // Random traffic with random bubbles and random backpressure.
    rnd_rdy = 1;
    e0 = n_emit;
    for (int i = 0; i < 300; i++) begin
      send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) tick();
    end
    rnd_rdy = 0;
    drain("drain_rnd");
    chk("rnd_emits", 32'(n_emit - e0), 32'd300);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
